// File: rtl/rca_ft_pkg.sv
// Shared definitions for the fault-tolerant ripple-carry adder.
// Holds the datapath sizes and the fault-map encoding. The encoding turns
// the index of a defective bit slice into the select vectors that steer
// operands, carries and sums around that slice onto the spare cell.
package rca_ft_pkg;

  localparam int NUM_BITS  = 4;
  localparam int NUM_CELLS = 5;

  // Index value meaning "no defective slice": all selects stay at zero
  localparam int unsigned NO_BYPASS = NUM_BITS;

  // Complete set of static select lines driven by the fault-map register
  typedef struct packed {
    logic [NUM_CELLS-1:0] is;   // cell input shift, one per cell
    logic                 is5;  // carry-out taken from the spare cell
    logic [NUM_CELLS-1:0] cs;   // carry-in skips the cell below
    logic [NUM_BITS-1:0]  ss;   // sum bit taken from the cell above
  } sel_t;

  // Build the select vectors that bypass slice idx; any idx outside 0..3
  // yields the plain adder configuration with the spare cell unused.
  function automatic sel_t bypass_sel(input int unsigned idx);
    sel_t r;
    r = '0;
    if (idx < NUM_BITS) begin
      for (int unsigned k = 0; k < NUM_CELLS; k++) begin
        if (k > idx) r.is[k] = 1'b1;
      end
      r.cs[idx+1] = 1'b1;
      for (int unsigned i = 0; i < NUM_BITS; i++) begin
        if (i >= idx) r.ss[i] = 1'b1;
      end
      r.is5 = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rca_fault_tolerant_if.sv
// Operand, select and result bundle of the fault-tolerant adder stage.
// The master side (datapath / fault-map controller) drives operands and
// selects; the slave side (the adder) returns the registered sum.
interface rca_fault_tolerant_if;
  import rca_ft_pkg::*;

  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                c1;
  logic                test;
  logic                is0, is1, is2, is3, is4, is5;
  logic                CS0, CS1, CS2, CS3, CS4;
  logic                SS0, SS1, SS2, SS3;
  logic [NUM_BITS:0]   A;
  logic [NUM_BITS:0]   B;
  logic [NUM_BITS-1:0] s;
  logic                cout;

  modport master (
    output a, b, c1, test,
    output is0, is1, is2, is3, is4, is5,
    output CS0, CS1, CS2, CS3, CS4,
    output SS0, SS1, SS2, SS3,
    output A, B,
    input  s, cout
  );

  modport slave (
    input  a, b, c1, test,
    input  is0, is1, is2, is3, is4, is5,
    input  CS0, CS1, CS2, CS3, CS4,
    input  SS0, SS1, SS2, SS3,
    input  A, B,
    output s, cout
  );

endinterface

// File: rtl/rca_ft_fa_cell.sv
// One-bit full adder slice; five of these form the repairable adder.
module rca_ft_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // Plain full-adder equations
  always_comb begin
    s  = x ^ y ^ ci;
    co = (x & y) | (ci & (x ^ y));
  end

endmodule

// File: rtl/rca_fault_tolerant.sv
// Registered 4-bit ripple-carry add stage with one spare full-adder cell.
// Static selects shift operands, carries and sums upward so that a single
// defective slice is skipped and the spare cell takes over the top bit.
// Each cell's carry and sum is a separate scalar so the carry chain does not
// read and write bits of one shared vector inside one combinational path.
module rca_fault_tolerant
  import rca_ft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  rca_fault_tolerant_if.slave  bus
);

  logic [NUM_CELLS-1:0] op_a, op_b;
  logic [NUM_CELLS:0]   op_a_ext, op_b_ext;
  logic [NUM_CELLS-1:0] is_v;
  logic [NUM_CELLS-1:0] x_v, y_v;
  logic                 ci0, ci1, ci2, ci3, ci4;
  logic                 co0, co1, co2, co3, co4;
  logic                 fs0, fs1, fs2, fs3, fs4;
  logic [NUM_BITS-1:0]  sum_nxt;
  logic                 cout_nxt;

  // Operand source: test operands carry a fifth bit for the spare cell,
  // mission operands leave that bit at zero. A zero is appended below bit 0
  // so a shifted cell 0 sees op[-1] = 0.
  always_comb begin
    op_a     = bus.test ? bus.A : {1'b0, bus.a};
    op_b     = bus.test ? bus.B : {1'b0, bus.b};
    op_a_ext = {op_a, 1'b0};
    op_b_ext = {op_b, 1'b0};
    is_v     = {bus.is4, bus.is3, bus.is2, bus.is1, bus.is0};
  end

  // Cell input steering: a shifted cell takes the operand bit one below
  always_comb begin
    x_v = '0;
    y_v = '0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      x_v[k] = is_v[k] ? op_a_ext[k] : op_a_ext[k+1];
      y_v[k] = is_v[k] ? op_b_ext[k] : op_b_ext[k+1];
    end
  end

  // Carry steering: a set CS line skips the cell directly below, with c1
  // standing in for cout(-1) and zero for cout(-2)
  always_comb begin
    ci0 = bus.CS0 ? 1'b0 : bus.c1;
    ci1 = bus.CS1 ? bus.c1 : co0;
    ci2 = bus.CS2 ? co0 : co1;
    ci3 = bus.CS3 ? co1 : co2;
    ci4 = bus.CS4 ? co2 : co3;
  end

  rca_ft_fa_cell u_fa0 (.x(x_v[0]), .y(y_v[0]), .ci(ci0), .s(fs0), .co(co0));
  rca_ft_fa_cell u_fa1 (.x(x_v[1]), .y(y_v[1]), .ci(ci1), .s(fs1), .co(co1));
  rca_ft_fa_cell u_fa2 (.x(x_v[2]), .y(y_v[2]), .ci(ci2), .s(fs2), .co(co2));
  rca_ft_fa_cell u_fa3 (.x(x_v[3]), .y(y_v[3]), .ci(ci3), .s(fs3), .co(co3));
  rca_ft_fa_cell u_fa4 (.x(x_v[4]), .y(y_v[4]), .ci(ci4), .s(fs4), .co(co4));

  // Result steering: each sum bit may come from the cell one above, and the
  // carry-out from the spare cell once the top slice has moved onto it
  always_comb begin
    sum_nxt[0] = bus.SS0 ? fs1 : fs0;
    sum_nxt[1] = bus.SS1 ? fs2 : fs1;
    sum_nxt[2] = bus.SS2 ? fs3 : fs2;
    sum_nxt[3] = bus.SS3 ? fs4 : fs3;
    cout_nxt   = bus.is5 ? co4 : co3;
  end

  // Output register with synchronous reset taking priority over new data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.s    <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.s    <= sum_nxt;
      bus.cout <= cout_nxt;
    end
  end

endmodule

// File: tb/tb_rca_fault_tolerant.sv
// Directed self-checking bench for the fault-tolerant registered adder.
module tb_rca_fault_tolerant;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rca_fault_tolerant_if bus_if ();

  rca_fault_tolerant dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all select lines: is[4:0], is5, CS[4:0], SS[3:0]
  task automatic setSelects(input logic [4:0] is_v, input logic is5,
                            input logic [4:0] cs_v, input logic [3:0] ss_v);
    bus_if.is0 = is_v[0]; bus_if.is1 = is_v[1]; bus_if.is2 = is_v[2];
    bus_if.is3 = is_v[3]; bus_if.is4 = is_v[4]; bus_if.is5 = is5;
    bus_if.CS0 = cs_v[0]; bus_if.CS1 = cs_v[1]; bus_if.CS2 = cs_v[2];
    bus_if.CS3 = cs_v[3]; bus_if.CS4 = cs_v[4];
    bus_if.SS0 = ss_v[0]; bus_if.SS1 = ss_v[1]; bus_if.SS2 = ss_v[2];
    bus_if.SS3 = ss_v[3];
  endtask

  // Drive operands, let one rising edge capture them, sample 1 time unit later
  task automatic applyStimulus(input logic test, input logic [3:0] a, input logic [3:0] b,
                               input logic [4:0] A, input logic [4:0] B, input logic c1);
    bus_if.test = test;
    bus_if.a    = a;
    bus_if.b    = b;
    bus_if.A    = A;
    bus_if.B    = B;
    bus_if.c1   = c1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp_s, input logic exp_cout);
    n_checks++;
    assert (bus_if.s === exp_s)
    else begin
      n_fail++;
      $error("[TB] FAIL %s.s observed=%b expected=%b", tag, bus_if.s, exp_s);
    end
    n_checks++;
    assert (bus_if.cout === exp_cout)
    else begin
      n_fail++;
      $error("[TB] FAIL %s.cout observed=%b expected=%b", tag, bus_if.cout, exp_cout);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    setSelects(5'b00000, 1'b0, 5'b00000, 4'b0000);

    // Reset state, with nonzero operands present
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b01111, 5'b01111, 1'b1);
    checkOutput("reset_init", 4'b0000, 1'b0);
    rst_n = 1'b1;

    // Plain adder, test operands
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b00001, 5'b00010, 1'b0);
    checkOutput("plain_1p2", 4'b0011, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b00001, 5'b00011, 1'b0);
    checkOutput("plain_1p3", 4'b0100, 1'b0);

    // Carry ripple
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b01001, 5'b00011, 1'b0);
    checkOutput("ripple_9p3", 4'b1100, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b01001, 5'b01011, 1'b0);
    checkOutput("ripple_9p11", 4'b0100, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b01100, 5'b01011, 1'b0);
    checkOutput("ripple_12p11", 4'b0111, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b01000, 5'b00111, 1'b0);
    checkOutput("ripple_8p7", 4'b1111, 1'b0);

    // Full carry chain through c1, and spare-cell bit ignored when unused
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b01111, 5'b00000, 1'b1);
    checkOutput("ripple_c1_wrap", 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b10001, 5'b10001, 1'b0);
    checkOutput("spare_unused", 4'b0010, 1'b0);

    // Bypass FA1
    setSelects(5'b11100, 1'b1, 5'b00100, 4'b1110);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b01001, 5'b01011, 1'b0);
    checkOutput("bypass1", 4'b0100, 1'b1);

    // Bypass FA1 with FA1 outputs forced to the wrong values
    force dut.fs1 = 1'b1;
    force dut.co1 = 1'b0;
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b01001, 5'b01011, 1'b0);
    checkOutput("bypass1_faulty", 4'b0100, 1'b1);
    release dut.fs1;
    release dut.co1;

    // Bypass FA0
    setSelects(5'b11110, 1'b1, 5'b00010, 4'b1111);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b00001, 5'b01110, 1'b0);
    checkOutput("bypass0_c0", 4'b1111, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b00001, 5'b01110, 1'b1);
    checkOutput("bypass0_c1", 4'b0000, 1'b1);

    // Bypass FA3: top slice moves onto the spare cell
    setSelects(5'b10000, 1'b1, 5'b10000, 4'b1000);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b01111, 5'b00001, 1'b0);
    checkOutput("bypass3", 4'b0000, 1'b1);

    // Mode mux
    setSelects(5'b00000, 1'b0, 5'b00000, 4'b0000);
    applyStimulus(1'b0, 4'b1100, 4'b0111, 5'b00000, 5'b00000, 1'b0);
    checkOutput("mission_mode", 4'b0011, 1'b1);
    applyStimulus(1'b1, 4'b1100, 4'b0111, 5'b00000, 5'b00000, 1'b0);
    checkOutput("test_mode_zero", 4'b0000, 1'b0);

    // Reset mid-stream has priority, release captures current inputs
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b01100, 5'b01011, 1'b0);
    checkOutput("reset_mid", 4'b0000, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0000, 4'b0000, 5'b01100, 5'b01011, 1'b0);
    checkOutput("reset_release", 4'b0111, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
